// File: rtl/sw_debounce_enable_if.sv
// Switch conditioning bus: raw pin in, debounced level, strobes and enable out.
// Signalling contract: there is no valid/ready handshake on this bus. sw_raw
// is a free-running asynchronous level; sw_level and enable_out are levels
// valid every cycle; press_pulse and release_pulse are single-cycle strobes
// that are never high together. state_dbg mirrors the debounce FSM state
// (0 STABLE_LO, 1 CHK_HI, 2 STABLE_HI, 3 CHK_LO) for observation only.
interface sw_debounce_enable_if;
  logic       sw_raw;
  logic       sw_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       enable_out;
  logic [1:0] state_dbg;

  // The conditioning block drives everything except the raw pin.
  modport slave (
    input  sw_raw,
    output sw_level,
    output press_pulse,
    output release_pulse,
    output enable_out,
    output state_dbg
  );

  // The switch side / environment drives the raw pin and observes the rest.
  modport master (
    output sw_raw,
    input  sw_level,
    input  press_pulse,
    input  release_pulse,
    input  enable_out,
    input  state_dbg
  );
endinterface

// File: rtl/sw_debounce_enable.sv
// Switch synchroniser + debouncer for the function-generator enable switches.
// A two-flop synchroniser feeds a four-state debounce FSM. A new level is
// accepted only after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
// The FSM then issues a one-cycle press or release strobe.
// Optional build macro SW_TOGGLE_MODE_EN: when defined, enable_out becomes a
// toggle register that flips on every accepted press. When undefined,
// enable_out simply follows sw_level.
module sw_debounce_enable #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic                  sysclk,
  input  logic                  reset,
  sw_debounce_enable_if.slave   sw
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_t;

  // Completion compare value: qualification ends when cnt reaches this value,
  // so the counter can never wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;
  logic             release_q;
  logic             release_d;

  // Two-flop synchroniser for the asynchronous pin; only s2 is used downstream.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw.sw_raw;
      s2 <= s1;
    end
  end

  // FSM state, counter and registered outputs; reset wins over any transition.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= STABLE_LO;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next-state logic. The counter is cleared on every state entry. A reversal
  // of s2 during a check state returns to the stable state it came from.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (s2) begin
          state_d = CHK_HI;
          cnt_d   = '0;
        end
      end
      CHK_HI: begin
        if (!s2) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!s2) begin
          state_d = CHK_LO;
          cnt_d   = '0;
        end
      end
      CHK_LO: begin
        if (s2) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = STABLE_LO;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign sw.sw_level      = level_q;
  assign sw.press_pulse   = press_q;
  assign sw.release_pulse = release_q;
  assign sw.state_dbg     = state_q;

`ifdef SW_TOGGLE_MODE_EN
  logic enable_q;

  // Toggle enable: flips the cycle after each press strobe; releases ignored.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      enable_q <= 1'b0;
    end else if (press_q) begin
      enable_q <= ~enable_q;
    end
  end

  assign sw.enable_out = enable_q;
`else
  assign sw.enable_out = level_q;
`endif

endmodule

// File: tb/tb_sw_debounce_enable.sv
// Directed bench for sw_debounce_enable with DEBOUNCE_CYCLES=8.
// Expected output vectors per edge are built from hand-derived event edges
// (press/release land on the 11th edge after the raw pin settles) into exp_q.
module tb_sw_debounce_enable;

  localparam int unsigned DEB = 8;

  logic sysclk;
  logic reset;

  sw_debounce_enable_if sw_bus ();

  sw_debounce_enable #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (4)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .sw     (sw_bus.slave)
  );

  // Clock / reset block
  initial begin
    sysclk = 1'b0;
    forever #10 sysclk = ~sysclk;
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  // Bench-side expectation state
  logic m_level      = 1'b0;
  logic m_en         = 1'b0;
  logic m_press_prev = 1'b0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hold reset for n edges, checking that every output is cleared.
  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(posedge sysclk); #1;
      check($sformatf("rst.lvl@%0d", i), 32'(sw_bus.sw_level), 32'd0);
      check($sformatf("rst.prs@%0d", i), 32'(sw_bus.press_pulse), 32'd0);
      check($sformatf("rst.rel@%0d", i), 32'(sw_bus.release_pulse), 32'd0);
      check($sformatf("rst.en@%0d", i), 32'(sw_bus.enable_out), 32'd0);
      check($sformatf("rst.st@%0d", i), 32'(sw_bus.state_dbg), 32'd0);
    end
    reset        = 1'b0;
    m_level      = 1'b0;
    m_en         = 1'b0;
    m_press_prev = 1'b0;
  endtask

  // Run n edges with sw_raw held; press_at/release_at are the edge numbers
  // (1-based, 0 = none) on which the strobe is expected.
  task automatic watch(input string tag, input int n, input int press_at, input int release_at);
    logic [3:0] e;
    for (int i = 1; i <= n; i++) begin
      if (i == press_at) m_level = 1'b1;
      if (i == release_at) m_level = 1'b0;
`ifdef SW_TOGGLE_MODE_EN
      if (m_press_prev) m_en = ~m_en;
`else
      m_en = m_level;
`endif
      m_press_prev = (i == press_at);
      exp_q.push_back({m_level, (i == press_at), (i == release_at), m_en});
    end
    for (int i = 1; i <= n; i++) begin
      @(posedge sysclk); #1;
      e = exp_q.pop_front();
      check($sformatf("%s.lvl@%0d", tag, i), 32'(sw_bus.sw_level), 32'(e[3]));
      check($sformatf("%s.prs@%0d", tag, i), 32'(sw_bus.press_pulse), 32'(e[2]));
      check($sformatf("%s.rel@%0d", tag, i), 32'(sw_bus.release_pulse), 32'(e[1]));
      check($sformatf("%s.en@%0d", tag, i), 32'(sw_bus.enable_out), 32'(e[0]));
    end
  endtask

  initial begin
    reset         = 1'b1;
    sw_bus.sw_raw = 1'b1;

    // 1: reset with raw high, then a clean press qualified on edge 11
    do_reset(3);
    watch("s1", 14, 11, 0);
    check("s1.state", 32'(sw_bus.state_dbg), 32'd2);

    // 4: drop to 0 from STABLE_HI, release on edge 11
    sw_bus.sw_raw = 1'b0;
    watch("s4", 14, 0, 11);
    check("s4.state", 32'(sw_bus.state_dbg), 32'd0);

    // 2: short 5-cycle pulse is rejected
    sw_bus.sw_raw = 1'b1;
    watch("s2a", 5, 0, 0);
    sw_bus.sw_raw = 1'b0;
    watch("s2b", 15, 0, 0);
    check("s2.state", 32'(sw_bus.state_dbg), 32'd0);

    // 3: toggle every 3 cycles for 30 cycles, then settle high
    for (int i = 0; i < 30; i++) begin
      sw_bus.sw_raw = (((i / 3) % 2) == 0) ? 1'b1 : 1'b0;
      watch("s3a", 1, 0, 0);
    end
    sw_bus.sw_raw = 1'b1;
    watch("s3b", 14, 11, 0);

    // 5: reset mid-qualification (CHK_HI, cnt=5) forces a full restart
    sw_bus.sw_raw = 1'b0;
    watch("s5r", 14, 0, 11);
    sw_bus.sw_raw = 1'b1;
    watch("s5a", 8, 0, 0);
    check("s5.chk_hi", 32'(sw_bus.state_dbg), 32'd1);
    do_reset(1);
    watch("s5b", 14, 11, 0);

    // 6: two clean press/release sequences (toggle behaviour under the macro)
    sw_bus.sw_raw = 1'b0;
    watch("s6r0", 14, 0, 11);
    sw_bus.sw_raw = 1'b1;
    watch("s6p1", 14, 11, 0);
    sw_bus.sw_raw = 1'b0;
    watch("s6r1", 14, 0, 11);
    sw_bus.sw_raw = 1'b1;
    watch("s6p2", 14, 11, 0);
    sw_bus.sw_raw = 1'b0;
    watch("s6r2", 14, 0, 11);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sw_debounce_enable.md
Name: sw_debounce_enable

Overview:
Upstream conditioning stage for the function-generator switches. It takes a raw, asynchronous, bouncing slide-switch input and synchronises and debounces it. It produces a clean registered level, one-cycle press/release strobes, and the enable level that drives Enable_SW_1 of the Sawwave_Generator (and the sibling waveform generators). One instance is used per switch.

Parameters:
DEBOUNCE_CYCLES, 500000, number of consecutive sysclk cycles the synchronised input must hold a new value before it is accepted (10 ms at 50 MHz); legal range 2..2^24-1.
CNT_W, 24, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
sysclk  input  1  system clock (50 MHz, 20 ns period)
reset  input  1  synchronous reset, active-high
sw_raw  input  1  raw switch pin, asynchronous, may bounce
sw_level  output  1  debounced switch level, registered
press_pulse  output  1  one-cycle strobe on accepted 0->1 transition
release_pulse  output  1  one-cycle strobe on accepted 1->0 transition
enable_out  output  1  enable level to the waveform generator (Enable_SW_1)

Behaviour:
- Clocking: all flops on the rising edge of sysclk. Reset is synchronous and active-high; there is no asynchronous path.
- Reset: sync flops = 0, state = STABLE_LO, counter = 0, and sw_level, press_pulse, release_pulse, enable_out all = 0. Reset has priority over every other event, including a transition in progress.
- Synchroniser: two-flop chain sw_raw -> s1 -> s2. The FSM uses only s2.
- FSM states: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
  - STABLE_LO: s2=1 -> CHK_HI with cnt=0; otherwise hold.
  - CHK_HI: s2=0 -> STABLE_LO with cnt=0 (glitch rejected, no strobe). s2=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI: sw_level<=1, press_pulse<=1 for that cycle. Otherwise cnt<=cnt+1.
  - STABLE_HI: s2=0 -> CHK_LO with cnt=0; otherwise hold.
  - CHK_LO: mirror of CHK_HI. s2=1 aborts back to STABLE_HI. Completion sets sw_level<=0 and release_pulse<=1.
- Latency: if sw_raw is sampled high at edge N and stays high, sw_level and press_pulse assert after edge N+DEBOUNCE_CYCLES+2, i.e. DEBOUNCE_CYCLES+3 edges counting edge N as 1. Release latency is symmetric.
- Bounce: any reversal of s2 during CHK_* restarts qualification from the stable state. A pulse shorter than DEBOUNCE_CYCLES cycles never changes the outputs.
- Strobes: exactly one cycle wide. press_pulse and release_pulse are never high together.
- Counter: cleared on every state entry; it never wraps because completion occurs at DEBOUNCE_CYCLES-1.
- enable_out (default build): equal to sw_level, same cycle.

Optional Feature:
Macro SW_TOGGLE_MODE_EN.
- Defined: enable_out is a toggle register. It inverts on every press_pulse, so it changes in the cycle after the strobe; release_pulse does not affect it. It resets to 0. sw_level and the strobes are unchanged.
- Undefined: enable_out = sw_level and no toggle register is built.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=8 and 20 ns sysclk.)
1. Hold reset 3 cycles with sw_raw=1, then release with sw_raw held 1 -> all outputs 0 during reset. sw_level rises on the 11th edge after reset deasserts; press_pulse is high for exactly that cycle.
2. sw_raw high for 5 cycles, then low -> sw_level, press_pulse and enable_out stay 0 throughout.
3. sw_raw toggling every 3 cycles for 30 cycles, then settling at 1 -> exactly one press_pulse, 11 edges after the final rising edge of sw_raw; no release_pulse.
4. From STABLE_HI, drop sw_raw to 0 and hold -> sw_level and enable_out fall 11 edges later; release_pulse high for one cycle.
5. Assert reset for 1 cycle while in CHK_HI with cnt=5 -> outputs 0 the next cycle. With sw_raw still 1, a full 11-edge qualification is needed before press_pulse.
6. Built with SW_TOGGLE_MODE_EN, two clean press/release sequences -> enable_out goes 0→1 after the first press_pulse and 1→0 after the second; it is unchanged on either release_pulse.
